// File: rtl/wb_stage_if.sv
// MEM/WB handshake bundle for the writeback stage.
// The o_retire_cnt member exists only when WB_RETIRE_CNT_EN is defined.
interface wb_stage_if;
  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_pc;
  logic        i_rd_wren;
  logic [4:0]  i_rd_addr;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_data;
  logic [31:0] i_ld_data;
  logic [2:0]  i_ld_type;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_valid;
  logic [31:0] o_pc;
  logic        o_misalign;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] o_retire_cnt;
`endif

  // The MEM stage (or a bench) drives the i_* side and observes the results.
  modport master (
    output i_stall, i_flush, i_valid, i_pc, i_rd_wren, i_rd_addr,
           i_wb_sel, i_alu_data, i_ld_data, i_ld_type,
    input  o_rd_wren, o_rd_addr, o_rd_data, o_valid, o_pc, o_misalign
`ifdef WB_RETIRE_CNT_EN
    , input o_retire_cnt
`endif
  );

  // The writeback stage consumes the i_* side and produces the results.
  modport slave (
    input  i_stall, i_flush, i_valid, i_pc, i_rd_wren, i_rd_addr,
           i_wb_sel, i_alu_data, i_ld_data, i_ld_type,
    output o_rd_wren, o_rd_addr, o_rd_data, o_valid, o_pc, o_misalign
`ifdef WB_RETIRE_CNT_EN
    , output o_retire_cnt
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage RV32I pipeline: MEM/WB register, result
// selection (ALU / aligned+extended load / PC+4), register-file write port
// and misaligned-load flag.
// Optional feature: define WB_RETIRE_CNT_EN to add a 32-bit retired-instruction
// counter on o_retire_cnt.
module wb_stage (
  input  logic       i_clk,
  input  logic       i_rst,
  wb_stage_if.slave  bus
);

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic        valid_q,  valid_d;
  logic [31:0] pc_q,     pc_d;
  logic        rdWren_q, rdWren_d;
  logic [4:0]  rdAddr_q, rdAddr_d;
  logic [1:0]  wbSel_q,  wbSel_d;
  logic [31:0] aluData_q, aluData_d;
  logic [31:0] ldData_q, ldData_d;
  logic [2:0]  ldType_q, ldType_d;

  logic [1:0]  offset;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] ldValue;
  logic        isHalf;
  logic        isWord;
  logic        misalign;
  logic [31:0] rdData;

  // Next-state of the MEM/WB register: flush beats stall, stall holds everything.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rdWren_d  = rdWren_q;
    rdAddr_d  = rdAddr_q;
    wbSel_d   = wbSel_q;
    aluData_d = aluData_q;
    ldData_d  = ldData_q;
    ldType_d  = ldType_q;
    if (bus.i_flush) begin
      valid_d   = 1'b0;
      pc_d      = 32'd0;
      rdWren_d  = 1'b0;
      rdAddr_d  = 5'd0;
      wbSel_d   = 2'b00;
      aluData_d = 32'd0;
      ldData_d  = 32'd0;
      ldType_d  = 3'b000;
    end else if (!bus.i_stall) begin
      valid_d   = bus.i_valid;
      pc_d      = bus.i_pc;
      rdWren_d  = bus.i_rd_wren;
      rdAddr_d  = bus.i_rd_addr;
      wbSel_d   = bus.i_wb_sel;
      aluData_d = bus.i_alu_data;
      ldData_d  = bus.i_ld_data;
      ldType_d  = bus.i_ld_type;
    end
  end

  // MEM/WB register with synchronous active-low reset overriding flush and stall.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_q   <= 1'b0;
      pc_q      <= 32'd0;
      rdWren_q  <= 1'b0;
      rdAddr_q  <= 5'd0;
      wbSel_q   <= 2'b00;
      aluData_q <= 32'd0;
      ldData_q  <= 32'd0;
      ldType_q  <= 3'b000;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rdWren_q  <= rdWren_d;
      rdAddr_q  <= rdAddr_d;
      wbSel_q   <= wbSel_d;
      aluData_q <= aluData_d;
      ldData_q  <= ldData_d;
      ldType_q  <= ldType_d;
    end
  end

  assign offset = aluData_q[1:0];
  assign ldByte = ldData_q[{offset, 3'b000} +: 8];
  assign ldHalf = ldData_q[{offset[1], 4'b0000} +: 16];

  // Load alignment and extension; unknown funct3 codes behave as LW.
  always_comb begin
    case (ldType_q)
      LD_LB:   ldValue = {{24{ldByte[7]}}, ldByte};
      LD_LBU:  ldValue = {24'd0, ldByte};
      LD_LH:   ldValue = {{16{ldHalf[15]}}, ldHalf};
      LD_LHU:  ldValue = {16'd0, ldHalf};
      default: ldValue = ldData_q;
    endcase
  end

  // Misalignment only matters for a valid load; byte loads can never trip it.
  always_comb begin
    isHalf   = (ldType_q == LD_LH) || (ldType_q == LD_LHU);
    isWord   = !isHalf && (ldType_q != LD_LB) && (ldType_q != LD_LBU);
    misalign = valid_q && (wbSel_q == SEL_LOAD) &&
               ((isHalf && offset[0]) || (isWord && (offset != 2'b00)));
  end

  // Result mux; code 11 falls back to the ALU result.
  always_comb begin
    case (wbSel_q)
      SEL_LOAD: rdData = ldValue;
      SEL_PC4:  rdData = pc_q + 32'd4;
      default:  rdData = aluData_q;
    endcase
  end

  assign bus.o_rd_data  = rdData;
  assign bus.o_rd_addr  = rdAddr_q;
  assign bus.o_pc       = pc_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_misalign = misalign;
  assign bus.o_rd_wren  = valid_q && rdWren_q && (rdAddr_q != 5'd0) &&
                          !misalign && !bus.i_stall;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retireCnt_q;

  // Count every non-stalled, non-misaligned valid instruction, even if it skips rd.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      retireCnt_q <= 32'd0;
    end else if (valid_q && !bus.i_stall && !misalign) begin
      retireCnt_q <= retireCnt_q + 32'd1;
    end
  end

  assign bus.o_retire_cnt = retireCnt_q;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RV32I pipeline. It holds the MEM/WB pipeline register and selects the result source: ALU, aligned and extended load, or PC+4. It drives the register-file write port and the WB forwarding path. It also flags misaligned loads and optionally counts retired instructions.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-low
- i_stall  in  1  hold MEM/WB register contents; suppresses the write and retire for the cycle
- i_flush  in  1  load a bubble into the MEM/WB register
- i_valid  in  1  MEM-stage instruction is valid
- i_pc  in  32  MEM-stage PC
- i_rd_wren  in  1  instruction writes rd
- i_rd_addr  in  5  destination register
- i_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 ALU
- i_alu_data  in  32  ALU result; low 2 bits are the byte offset for loads
- i_ld_data  in  32  raw 32-bit word read from data memory
- i_ld_type  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are treated as LW
- o_rd_wren  out  1  register-file write enable
- o_rd_addr  out  5  register-file write address
- o_rd_data  out  32  register-file write data; the same value feeds the forwarding mux
- o_valid  out  1  WB stage holds a valid instruction
- o_pc  out  32  WB-stage PC
- o_misalign  out  1  WB instruction is a misaligned load
- o_retire_cnt  out  32  retired-instruction count; present only with WB_RETIRE_CNT_EN

## Operation
- Register capture, each rising edge:
  - If !i_rst: all fields clear (valid=0, pc=0, rd_addr=0, wren=0, wb_sel=00, data=0, ld_type=000).
  - Else if i_flush: valid=0 and wren=0; other fields don't-care, cleared to 0.
  - Else if i_stall: hold all fields.
  - Else: capture every i_* field.
- Load extraction uses registered offset = alu_data[1:0]:
  - LB/LBU: byte = ld_data[8*offset +: 8], sign- or zero-extended.
  - LH/LHU: half = ld_data[16*offset[1] +: 16], sign- or zero-extended.
  - LW: whole word.
- Misalignment, applied only when wb_sel=01 and valid:
  - LH/LHU with offset[0]=1 is misaligned.
  - LW with offset≠00 is misaligned.
  - Byte loads are never misaligned.
- o_rd_data by wb_sel:
  - ALU: alu_data.
  - load: extracted value.
  - PC+4: pc+32'd4, modulo 2^32.
- o_rd_wren = valid & wren & (rd_addr≠0) & !o_misalign & !i_stall.
- A stalled instruction therefore writes exactly once, in the first cycle i_stall is low.
- o_rd_addr, o_pc and o_valid are the registered fields.
- o_misalign is combinational from registered fields. It stays high as long as the instruction is held.

## Timing
- Latency: an instruction presented at edge N drives o_rd_* during cycle N..N+1. The register file commits it at edge N+1.
- Reset values of all outputs: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_valid=0, o_pc=0, o_misalign=0, o_retire_cnt=0.
- i_flush and i_stall both high: flush wins.
- i_rst low overrides flush and stall.
- Reset mid-stall discards the held instruction; no write occurs.
- Outputs depend combinationally on i_stall for write-enable gating only. All other outputs come from registers.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - o_retire_cnt port and a 32-bit counter exist.
  - Counter increments on each rising edge where valid & !i_stall & !o_misalign, whether or not the instruction writes rd.
  - Counter wraps 0xFFFFFFFF→0 and clears on reset.
- Macro not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then ALU op: capture x5, wb_sel=00, alu=0x1234_5678, wren=1 → next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0x1234_5678; earlier reset cycles show all outputs 0.
- Loads from word 0x8081_F0FF:
  - LB offset 1 → 0xFFFF_FFF0.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_8081.
  - LHU offset 0 → 0x0000_F0FF.
- Misaligned: LW offset 2, rd=7 → o_misalign=1, o_rd_wren=0, counter unchanged. LH offset 1 → same.
- JAL writeback: wb_sel=10, pc=0xFFFF_FFFC → o_rd_data=0x0000_0000. rd=0 with wren=1 → o_rd_wren=0 but the instruction is counted.
- Stall and flush:
  - Stall 3 cycles with valid ALU op in WB → o_rd_wren=0 for 3 cycles, then 1 for exactly one cycle; counter +1 total.
  - stall=flush=1 → o_valid=0 next cycle.
- Counter wrap (WB_RETIRE_CNT_EN): force count to 0xFFFF_FFFF, retire one → 0x0000_0000.
